jesd204_tx_link_sequencer: RTL
==============================

// Module: jesd204_tx_link_sequencer
// PURPOSE
//  Bring-up/recovery sequencer for a single-clock JESD204 TX link (ASYNC_CLK=0).
//  Holds the TX core in reset, releases it, waits for SYSREF alignment and for
//  every enabled link to release SYNC~, then supervises the DATA phase.
//  On a timeout or a sustained SYNC~ loss it retries up to a programmable limit.
//  Sits between the register map and the reset input of the jesd204_tx core.
// PARAMETERS
//  NUM_LINKS        1   number of SYNC~ inputs
//  RESET_CYCLES     16  cycles link_reset is held in RESET_LINK (>=1)
//  SYNC_LOSS_CYCLES 4   consecutive low cycles of an enabled SYNC~ in DATA that count as loss (>=1)
// PORTS
//  clk                 in   1          link clock
//  reset               in   1          asynchronous, active-high
//  ctrl_enable         in   1          1 = run the sequence; 0 = return to IDLE
//  sysref_edge         in   1          1-cycle event from core device_event_sysref_edge
//  lmfc_edge           in   1          core lmfc_edge
//  sync                in   NUM_LINKS  SYNC~ from converters, asynchronous, low = request
//  cfg_links_disable   in   NUM_LINKS  1 = ignore that link's SYNC~
//  cfg_timeout         in   16         wait-state timeout in cycles; 0 = no timeout
//  cfg_max_retries     in   8          retries allowed before FAILED
//  link_reset          out  1          reset to TX core
//  status_state        out  3          current state encoding
//  status_retry_count  out  8          retries taken since leaving IDLE
//  event_timeout       out  1          1-cycle pulse on timeout
//  event_sync_lost     out  1          1-cycle pulse on SYNC~ loss in DATA
// BEHAVIOUR
//  Reset values: link_reset=1, status_state=IDLE(0), status_retry_count=0, events=0.
//  SYNC~ is passed through a 2-flop synchronizer, giving 2 cycles of latency.
//  sync_ok = &(sync_s | cfg_links_disable). It is 1 when all links are disabled.
//  All outputs are registered. link_reset = 1 while the state is IDLE, RESET_LINK or FAILED.
//  It changes on the same edge as the state register.
//  States: IDLE=0, RESET_LINK=1, WAIT_SYSREF=2, WAIT_SYNC=3, DATA=4, FAILED=5.
//  - IDLE: if ctrl_enable=1 -> RESET_LINK, and status_retry_count is cleared.
//  - RESET_LINK: held for exactly RESET_CYCLES cycles -> WAIT_SYSREF.
//  - WAIT_SYSREF: sysref_edge=1 -> WAIT_SYNC.
//  - WAIT_SYNC: sync_ok=1 in the same cycle as lmfc_edge=1 -> DATA.
//  - DATA: an enabled synchronized SYNC~ is low for SYNC_LOSS_CYCLES consecutive cycles
//    -> event_sync_lost pulse, then the retry path. The low-run counter is cleared on
//    any cycle where sync_ok=1.
//  - FAILED: terminal. Leaves only via ctrl_enable=0.
//  Timeout:
//  - Timer loads cfg_timeout on entry to WAIT_SYSREF and to WAIT_SYNC.
//  - Expiry occurs after cfg_timeout cycles in the state -> event_timeout pulse, then
//    the retry path.
//  - cfg_timeout=0 disables the timer.
//  Retry path:
//  - If status_retry_count < cfg_max_retries: go to RESET_LINK and increment the count
//    (saturating at 255).
//  - Otherwise: go to FAILED and leave the count unchanged.
//  Priority (highest first): ctrl_enable=0 (-> IDLE next edge, from any state)
//    > progress condition > timeout/loss.
//  A qualifying edge in the timeout cycle therefore wins and no event fires.
//  cfg_* inputs are sampled live; changing them mid-sequence affects only future
//  comparisons.
//  Asynchronous reset mid-sequence: immediate return to the reset values.
// STRUCTURE
//  Shared header jesd204_tx_seq_defs.vh: state encodings and the STATE_W=3 localparam.
//  Sub-module jesd204_tx_seq_timer: 16-bit loadable down-counter with expire pulse and
//  zero-disables behaviour.
//  Reuse sync_bits (NUM_OF_BITS=NUM_LINKS, ASYNC_CLK=1) for the SYNC~ synchronizer.
// TESTING
//  1. Nominal bring-up.
//     Stimulus: enable=1, sysref_edge 40 cycles after link_reset falls; all sync=1 before
//     the next lmfc_edge.
//     Required: link_reset=1 for 16 cycles; state goes 1->2->3->4; link_reset=0 in DATA;
//     retry_count=0.
//  2. SYSREF timeout.
//     Stimulus: cfg_timeout=100, cfg_max_retries=2, no sysref.
//     Required: event_timeout pulses exactly 100 cycles after each WAIT_SYSREF entry;
//     retry_count goes 1 then 2; the third timeout gives FAILED with link_reset=1.
//  3. SYNC~ loss.
//     Stimulus: in DATA, sync[0] low for 3 cycles, then low for 4 cycles.
//     Required: no event for the 3-cycle glitch; the 4-cycle drop gives one
//     event_sync_lost, then RESET_LINK with retry_count=1.
//  4. Disabled link.
//     Stimulus: NUM_LINKS=2, cfg_links_disable=2'b10, sync[1] held low.
//     Required: DATA is reached and held; sync[1] never causes loss.
//  5. Abort and async reset.
//     Stimulus: ctrl_enable=0 in WAIT_SYNC, with a timeout expiring the same cycle.
//     Required: IDLE next edge and no event_timeout.
//     Stimulus: reset pulse in DATA.
//     Required: all outputs at their reset values without waiting for a clk edge.
//  6. Zero timeout.
//     Stimulus: cfg_timeout=0, no sysref for 70000 cycles.
//     Required: stays in WAIT_SYSREF with no event.

Source files
------------

// File: rtl/jesd204_tx_link_sequencer_pkg.sv
// Shared types for the JESD204 TX link sequencer: state encodings, field widths
// and small state-classification helpers.
package jesd204_tx_link_sequencer_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned TIMER_W = 16;
    localparam int unsigned RETRY_W = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE        = 3'd0,
        ST_RESET_LINK  = 3'd1,
        ST_WAIT_SYSREF = 3'd2,
        ST_WAIT_SYNC   = 3'd3,
        ST_DATA        = 3'd4,
        ST_FAILED      = 3'd5
    } state_e;

    // States in which the TX core must be held in reset
    function automatic logic holds_link_reset(input state_e s);
        return (s == ST_IDLE) || (s == ST_RESET_LINK) || (s == ST_FAILED);
    endfunction

    function automatic logic is_wait_state(input state_e s);
        return (s == ST_WAIT_SYSREF) || (s == ST_WAIT_SYNC);
    endfunction

endpackage

// File: rtl/jesd204_tx_seq_timer.sv
// Loadable 16-bit down-counter for the wait-state timeout. A load value of 0
// disables expiry; expire_o is a registered pulse in the N-th cycle after load.
module jesd204_tx_seq_timer
    import jesd204_tx_link_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic [TIMER_W-1:0] value_i,
    input  logic               run_i,
    output logic               expire_o
);

    logic [TIMER_W-1:0] cnt_q, cnt_d;
    logic               expire_q, expire_d;

    // Expiry is decided one cycle early so the pulse lands exactly N cycles after load
    always_comb begin
        cnt_d    = cnt_q;
        expire_d = 1'b0;
        if (load_i) begin
            cnt_d    = value_i;
            expire_d = (value_i == TIMER_W'(1));
        end else if (run_i && (cnt_q != '0)) begin
            cnt_d    = cnt_q - TIMER_W'(1);
            expire_d = (cnt_q == TIMER_W'(2));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            expire_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            expire_q <= expire_d;
        end
    end

    assign expire_o = expire_q;

endmodule

// File: rtl/jesd204_tx_link_sequencer.sv
// Bring-up/recovery sequencer for a single-clock JESD204 TX link: resets the core,
// waits for SYSREF and SYNC~ release, supervises DATA and retries on failures.
module jesd204_tx_link_sequencer
    import jesd204_tx_link_sequencer_pkg::*;
#(
    parameter int unsigned NUM_LINKS        = 1,
    parameter int unsigned RESET_CYCLES     = 16,
    parameter int unsigned SYNC_LOSS_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ctrl_enable,
    input  logic                 sysref_edge,
    input  logic                 lmfc_edge,
    input  logic [NUM_LINKS-1:0] sync,
    input  logic [NUM_LINKS-1:0] cfg_links_disable,
    input  logic [TIMER_W-1:0]   cfg_timeout,
    input  logic [RETRY_W-1:0]   cfg_max_retries,
    output logic                 link_reset,
    output logic [STATE_W-1:0]   status_state,
    output logic [RETRY_W-1:0]   status_retry_count,
    output logic                 event_timeout,
    output logic                 event_sync_lost
);

    localparam int unsigned RST_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int unsigned LOSS_W = (SYNC_LOSS_CYCLES > 1) ? $clog2(SYNC_LOSS_CYCLES) : 1;

    state_e               state_q, state_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic [RST_W-1:0]     rst_cnt_q, rst_cnt_d;
    logic [LOSS_W-1:0]    loss_cnt_q, loss_cnt_d;
    logic                 link_reset_q, link_reset_d;
    logic                 ev_timeout_q, ev_timeout_d;
    logic                 ev_sync_lost_q, ev_sync_lost_d;
    logic [NUM_LINKS-1:0] sync_meta_q, sync_s_q;
    logic                 sync_ok;
    logic                 timer_load;
    logic                 timer_expire;
    logic                 retry_req;

    // Two-flop synchronizer for the asynchronous SYNC~ lines
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta_q <= '0;
            sync_s_q    <= '0;
        end else begin
            sync_meta_q <= sync;
            sync_s_q    <= sync_meta_q;
        end
    end

    assign sync_ok = &(sync_s_q | cfg_links_disable);

    jesd204_tx_seq_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load_i   (timer_load),
        .value_i  (cfg_timeout),
        .run_i    (is_wait_state(state_q)),
        .expire_o (timer_expire)
    );

    // Next state: disable beats progress, progress beats timeout/loss
    always_comb begin
        state_d        = state_q;
        retry_d        = retry_q;
        rst_cnt_d      = rst_cnt_q;
        loss_cnt_d     = loss_cnt_q;
        ev_timeout_d   = 1'b0;
        ev_sync_lost_d = 1'b0;
        timer_load     = 1'b0;
        retry_req      = 1'b0;

        if (!ctrl_enable) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d   = ST_RESET_LINK;
                    retry_d   = '0;
                    rst_cnt_d = RST_W'(RESET_CYCLES - 1);
                end
                ST_RESET_LINK: begin
                    if (rst_cnt_q == '0) begin
                        state_d    = ST_WAIT_SYSREF;
                        timer_load = 1'b1;
                    end else begin
                        rst_cnt_d = rst_cnt_q - RST_W'(1);
                    end
                end
                ST_WAIT_SYSREF: begin
                    if (sysref_edge) begin
                        state_d    = ST_WAIT_SYNC;
                        timer_load = 1'b1;
                    end else if (timer_expire) begin
                        ev_timeout_d = 1'b1;
                        retry_req    = 1'b1;
                    end
                end
                ST_WAIT_SYNC: begin
                    if (sync_ok && lmfc_edge) begin
                        state_d    = ST_DATA;
                        loss_cnt_d = '0;
                    end else if (timer_expire) begin
                        ev_timeout_d = 1'b1;
                        retry_req    = 1'b1;
                    end
                end
                ST_DATA: begin
                    if (sync_ok) begin
                        loss_cnt_d = '0;
                    end else if (loss_cnt_q == LOSS_W'(SYNC_LOSS_CYCLES - 1)) begin
                        ev_sync_lost_d = 1'b1;
                        retry_req      = 1'b1;
                        loss_cnt_d     = '0;
                    end else begin
                        loss_cnt_d = loss_cnt_q + LOSS_W'(1);
                    end
                end
                ST_FAILED: begin
                    state_d = ST_FAILED;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (retry_req) begin
            if (retry_q < cfg_max_retries) begin
                state_d   = ST_RESET_LINK;
                retry_d   = (retry_q == '1) ? retry_q : retry_q + RETRY_W'(1);
                rst_cnt_d = RST_W'(RESET_CYCLES - 1);
            end else begin
                state_d = ST_FAILED;
            end
        end

        link_reset_d = holds_link_reset(state_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            retry_q        <= '0;
            rst_cnt_q      <= '0;
            loss_cnt_q     <= '0;
            link_reset_q   <= 1'b1;
            ev_timeout_q   <= 1'b0;
            ev_sync_lost_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            retry_q        <= retry_d;
            rst_cnt_q      <= rst_cnt_d;
            loss_cnt_q     <= loss_cnt_d;
            link_reset_q   <= link_reset_d;
            ev_timeout_q   <= ev_timeout_d;
            ev_sync_lost_q <= ev_sync_lost_d;
        end
    end

    assign link_reset         = link_reset_q;
    assign status_state       = state_q;
    assign status_retry_count = retry_q;
    assign event_timeout      = ev_timeout_q;
    assign event_sync_lost    = ev_sync_lost_q;

endmodule
